// File: rtl/seq_calc_pkg.sv
// seq_calc_pkg: op/state encodings and default widths shared by the recurrence engine
package seq_calc_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 6;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SEED0 = 3'd1;
    localparam logic [2:0] S_SEED1 = 3'd2;
    localparam logic [2:0] S_CALC  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
endpackage

// File: rtl/seq_calc_if.sv
// seq_calc_if: host handshake, RAM write port and readback port of seq_calc_engine
interface seq_calc_if
    import seq_calc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              start;
    logic [DATA_W-1:0] seed0;
    logic [DATA_W-1:0] seed1;
    logic [ADDR_W:0]   count;
    logic [1:0]        op;
    logic              busy;
    logic              done;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              ovf;
    modport master (
        output start, seed0, seed1, count, op, rd_addr,
        input  busy, done, mem_we, mem_addr, mem_wdata, rd_data, ovf
    );
    modport slave (
        input  start, seed0, seed1, count, op, rd_addr,
        output busy, done, mem_we, mem_addr, mem_wdata, rd_data, ovf
    );
endinterface

// File: rtl/seq_regfile.sv
// seq_regfile: DEPTH x DATA_W register file, one write port, one registered read port, sync clear
module seq_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    // a read of the address being written returns the pre-write contents
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
            if (we) mem[waddr] <= wdata;
        end
    end
endmodule

// File: rtl/seq_calc_engine.sv
// seq_calc_engine: a[i]=a[i-1] OP a[i-2] into regfile and RAM; SEQ_CALC_OVF_EN builds the sticky ovf flag
module seq_calc_engine
    import seq_calc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 64
) (
    input logic       clk,
    input logic       rst,
    seq_calc_if.slave bus
);
    logic [2:0]        state;
    logic [2:0]        next_state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] last;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [ADDR_W:0]   n_clamp;
    logic [1:0]        op_r;
    logic [DATA_W-1:0] p1;
    logic [DATA_W-1:0] p2;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              accept;
    logic              wr_en;
    logic              busy_r;
    logic              done_r;
    logic              mem_we_r;

    // the visible done cycle is still treated as part of the run, so start is ignored there
    assign accept  = state == S_IDLE && bus.start && !done_r;
    assign n_clamp = bus.count < (ADDR_W+1)'(2) ? (ADDR_W+1)'(2) :
                     bus.count > (ADDR_W+1)'(DEPTH) ? (ADDR_W+1)'(DEPTH) : bus.count;

    always_comb begin
        wr_en      = state == S_SEED0 || state == S_SEED1 || state == S_CALC;
        wr_addr    = state == S_SEED0 ? '0 : state == S_SEED1 ? ADDR_W'(1) : idx;
        alu        = op_r == OP_ADD ? p1 + p2 : op_r == OP_SUB ? p1 - p2 :
                     op_r == OP_AND ? (p1 & p2) : (p1 ^ p2);
        wr_data    = state == S_SEED0 ? p2 : state == S_SEED1 ? p1 : alu;
        next_state = state == S_IDLE  ? (accept ? S_SEED0 : S_IDLE) :
                     state == S_SEED0 ? S_SEED1 :
                     state == S_SEED1 ? (last == ADDR_W'(1) ? S_DONE : S_CALC) :
                     state == S_CALC  ? (idx == last ? S_DONE : S_CALC) : S_IDLE;
    end

    // p2/p1 hold a[i-2]/a[i-1]; the seeds are parked there until written out
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            idx         <= '0;
            last        <= '0;
            op_r        <= '0;
            p1          <= '0;
            p2          <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
        end else begin
            state    <= next_state;
            busy_r   <= accept || wr_en;
            done_r   <= state == S_DONE;
            mem_we_r <= wr_en;
            if (wr_en) begin
                mem_addr_r  <= wr_addr;
                mem_wdata_r <= wr_data;
            end
            if (accept) begin
                op_r <= bus.op;
                p2   <= bus.seed0;
                p1   <= bus.seed1;
                last <= ADDR_W'(n_clamp - (ADDR_W+1)'(1));
            end
            if (state == S_SEED1) idx <= ADDR_W'(2);
            if (state == S_CALC) begin
                p2  <= p1;
                p1  <= alu;
                idx <= idx + ADDR_W'(1);
            end
        end
    end

`ifdef SEQ_CALC_OVF_EN
    logic ovf_r;
    // carry-out of the add shows up as a wrapped sum smaller than an operand
    always_ff @(posedge clk) begin
        if (rst || accept) ovf_r <= 1'b0;
        else if (state == S_CALC && (op_r == OP_ADD ? alu < p1 : op_r == OP_SUB && p1 < p2)) ovf_r <= 1'b1;
    end
    assign bus.ovf = ovf_r;
`else
    assign bus.ovf = 1'b0;
`endif

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;

    seq_regfile #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_rf (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (bus.rd_addr),
        .rdata (bus.rd_data)
    );
endmodule

// File: tb/tb_seq_calc_engine.sv
// tb_seq_calc_engine: random and directed runs checked every cycle against a sequence-level model
module tb_seq_calc_engine;
    import seq_calc_pkg::*;
`ifdef SEQ_CALC_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_calc_if #(.DATA_W(32), .ADDR_W(6)) bus ();
    seq_calc_engine #(.DATA_W(32), .ADDR_W(6), .DEPTH(64)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad = 0;

    logic [31:0] m_mem [64];
    logic [31:0] seq [64];
    bit          ovf_term [64];
    bit          m_active = 0;
    bit          m_init = 0;
    int          m_t = 0;
    int          m_n = 0;
    logic        e_busy = 0, e_done = 0, e_we = 0, e_ovf = 0;
    logic [5:0]  e_addr = 0;
    logic [31:0] e_wdata = 0, e_rd = 0;

    bit          hold_rd = 0;
    logic [5:0]  hold_val = 0;
    logic [31:0] obs [64];
    logic [31:0] rd_hist [200];
    int          r_nw, r_done, r_last;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // one edge of the reference: a run of N terms writes a[t-1] on edge t, done follows edge N+1
    task automatic model_step();
        logic [31:0] rd_old, a, b;
        logic [32:0] w;
        bit acc;
        int n;
        if (rst) begin
            foreach (m_mem[i]) m_mem[i] = '0;
            m_active = 0;
            m_init = 1;
            {e_busy, e_done, e_we, e_ovf} = '0;
            e_addr = '0;
            e_wdata = '0;
            e_rd = '0;
            return;
        end
        rd_old = m_mem[bus.rd_addr];
        acc = !m_active && bus.start && !e_done;
        e_done = 0;
        e_we = 0;
        e_busy = 0;
        if (m_active) begin
            m_t++;
            if (m_t <= m_n) begin
                m_mem[m_t-1] = seq[m_t-1];
                e_we = 1;
                e_addr = 6'(m_t-1);
                e_wdata = seq[m_t-1];
                e_busy = 1;
                if (ovf_term[m_t-1]) e_ovf = 1;
            end else begin
                e_done = 1;
                m_active = 0;
            end
        end else if (acc) begin
            n = int'(bus.count);
            m_n = n < 2 ? 2 : (n > 64 ? 64 : n);
            seq[0] = bus.seed0;
            seq[1] = bus.seed1;
            ovf_term[0] = 0;
            ovf_term[1] = 0;
            for (int i = 2; i < m_n; i++) begin
                a = seq[i-1];
                b = seq[i-2];
                w = {1'b0, a} + {1'b0, b};
                case (bus.op)
                    OP_ADD: begin seq[i] = a + b; ovf_term[i] = w[32]; end
                    OP_SUB: begin seq[i] = a - b; ovf_term[i] = a < b; end
                    OP_AND: begin seq[i] = a & b; ovf_term[i] = 0; end
                    default: begin seq[i] = a ^ b; ovf_term[i] = 0; end
                endcase
                if (!OVF_ON) ovf_term[i] = 0;
            end
            m_active = 1;
            m_t = 0;
            e_busy = 1;
            e_ovf = 0;
        end
        e_rd = rd_old;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_init) begin
            chk("busy", 32'(bus.busy), 32'(e_busy));
            chk("done", 32'(bus.done), 32'(e_done));
            chk("mem_we", 32'(bus.mem_we), 32'(e_we));
            chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
            chk("mem_wdata", bus.mem_wdata, e_wdata);
            chk("rd_data", bus.rd_data, e_rd);
            chk("ovf", 32'(bus.ovf), 32'(e_ovf));
        end
    end

    initial forever begin
        @(posedge clk);
        #2;
        bus.rd_addr = hold_rd ? hold_val : 6'($urandom);
    end

    task automatic run(input logic [31:0] s0, input logic [31:0] s1, input logic [6:0] cnt,
                       input logic [1:0] o, input bit noise, input int mid_edge, input bit done_poke);
        @(negedge clk);
        bus.seed0 = s0;
        bus.seed1 = s1;
        bus.count = cnt;
        bus.op = o;
        bus.start = 1;
        r_nw = 0;
        r_done = -1;
        r_last = -1;
        for (int e = 0; e < 200; e++) begin
            @(negedge clk);
            bus.start = 0;
            rd_hist[e] = bus.rd_data;
            if (bus.mem_we) begin
                obs[bus.mem_addr] = bus.mem_wdata;
                r_nw++;
                r_last = int'(bus.mem_addr);
            end
            if (bus.done) begin
                r_done = e;
                bus.start = done_poke;
                break;
            end
            if (noise && $urandom_range(0, 3) == 0) begin
                bus.start = 1;
                bus.seed0 = $urandom;
                bus.seed1 = $urandom;
                bus.count = 7'($urandom);
                bus.op = 2'($urandom);
            end
            if (e == mid_edge) begin
                bus.start = 1;
                bus.seed0 = 32'hdead;
                bus.seed1 = 32'hbeef;
                bus.count = 7'd5;
                bus.op = OP_XOR;
            end
        end
        total++;
        if (r_done < 0) begin
            bad++;
            $display("FAIL run_timeout got=no_done want=done");
        end
    endtask

    initial begin
        int fib [10] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34};
        bit found;
        bus.start = 0;
        bus.seed0 = 0;
        bus.seed1 = 0;
        bus.count = 0;
        bus.op = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_we", 32'(bus.mem_we), 0);
        chk("rst_rd", bus.rd_data, 0);
        chk("rst_ovf", 32'(bus.ovf), 0);
        rst = 0;

        run(0, 1, 10, OP_ADD, 0, -1, 0);
        chk("fib_done_edge", r_done, 11);
        chk("fib_writes", r_nw, 10);
        for (int i = 0; i < 10; i++) chk("fib_val", obs[i], fib[i]);
        chk("model_fib9", m_mem[9], 34);

        hold_val = 7;
        hold_rd = 1;
        @(negedge clk);
        @(negedge clk);
        chk("rd7", bus.rd_data, 13);
        run(100, 200, 10, OP_ADD, 0, -1, 0);
        chk("rd7_same_edge_old", rd_hist[8], 13);
        chk("rd7_after_write", rd_hist[9], 3400);
        hold_rd = 0;

        run(10, 3, 3, OP_SUB, 0, -1, 0);
        chk("sub_a2", obs[2], 32'hFFFFFFF9);
        chk("sub_ovf", 32'(bus.ovf), 32'(OVF_ON));
        run(6, 3, 2, OP_AND, 0, -1, 0);
        chk("ovf_cleared", 32'(bus.ovf), 0);
        chk("and_writes", r_nw, 2);

        run(5, 7, 0, OP_XOR, 0, -1, 0);
        chk("clamp_lo_writes", r_nw, 2);
        chk("clamp_lo_done", r_done, 3);
        chk("clamp_lo_last", r_last, 1);
        run(1, 2, 127, OP_ADD, 0, -1, 0);
        chk("clamp_hi_writes", r_nw, 64);
        chk("clamp_hi_last", r_last, 63);
        chk("clamp_hi_done", r_done, 65);

        run(0, 1, 10, OP_ADD, 0, 5, 1);
        chk("busy_start_writes", r_nw, 10);
        chk("busy_start_a9", obs[9], 34);
        chk("busy_start_done", r_done, 11);
        @(negedge clk);
        bus.start = 0;
        chk("done_start_ignored", 32'(bus.busy), 0);
        run(2, 3, 4, OP_XOR, 0, -1, 0);
        chk("idle_start_writes", r_nw, 4);
        chk("idle_start_a3", obs[3], 2);

        @(negedge clk);
        bus.seed0 = 1;
        bus.seed1 = 1;
        bus.count = 20;
        bus.op = OP_ADD;
        bus.start = 1;
        found = 0;
        for (int e = 0; e < 30; e++) begin
            @(negedge clk);
            bus.start = 0;
            if (bus.mem_we && bus.mem_addr == 6'd4) begin
                found = 1;
                break;
            end
        end
        chk("rst_reach_idx5", 32'(found), 1);
        hold_val = 3;
        hold_rd = 1;
        rst = 1;
        @(negedge clk);
        chk("midrst_busy", 32'(bus.busy), 0);
        chk("midrst_we", 32'(bus.mem_we), 0);
        chk("midrst_done", 32'(bus.done), 0);
        rst = 0;
        @(negedge clk);
        chk("midrst_rd3", bus.rd_data, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("midrst_no_done", 32'(bus.done), 0);
        end
        hold_rd = 0;

        for (int r = 0; r < 30; r++)
            run($urandom, $urandom, 7'($urandom), 2'($urandom), 1, -1, 0);
        @(negedge clk);
        bus.start = 0;
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
